// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller.
//   reg_idx_e  : register index decoded from bus address bits [4:2]
//   first_set  : 1-based index of the lowest set bit, 0 when none set
package irq_controller_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    REG_PEND  = 3'd0,
    REG_MASK  = 3'd1,
    REG_MODE  = 3'd2,
    REG_POL   = 3'd3,
    REG_VEC   = 3'd4,
    REG_FORCE = 3'd5
  } reg_idx_e;

  // Scans from the top down so the lowest set bit is the last one written.
  function automatic logic [5:0] first_set(input logic [DATA_W-1:0] v);
    logic [5:0] r;
    r = '0;
    for (int unsigned k = DATA_W; k > 0; k--) begin
      if (v[k-1]) r = 6'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone register-port bundle (32-bit data, byte address).
//   master : drives cyc, stb, we, adr, sel, dat_w
//   slave  : drives ack, stall, dat_r
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;

  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, stall);
  modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, stall);
endinterface

// File: rtl/irq_sync.sv
// Per-source front end: synchronizer, polarity normalisation, edge detect.
//   clk_i, rst_i : clock, synchronous active-high reset
//   raw          : asynchronous interrupt request
//   pol          : 1 inverts the synchronized request (active-low source)
//   level        : normalised level s
//   rise         : s went 0 -> 1 relative to the previous cycle
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw,
  input  logic pol,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  // fill_q tracks how far real samples have travelled down sync_q since
  // reset, so the all-zero reset contents are never mistaken for a low input.
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   level_q;
  logic                   hist_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q       <= '0;
      fill_q       <= '0;
      level_q      <= 1'b0;
      hist_valid_q <= 1'b0;
    end else begin
      sync_q[0] <= raw;
      fill_q[0] <= 1'b1;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
        fill_q[k] <= fill_q[k-1];
      end
      level_q      <= level;
      hist_valid_q <= fill_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1] ^ pol;

  // An edge needs a previous level that came from a real sample; an input
  // held high through reset therefore has to fall and rise again.
  assign rise = hist_valid_q & level & ~level_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller with Wishbone register port.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus           : Wishbone slave; registers at adr[4:2]:
//                   0 PEND (R, W1C), 1 MASK, 2 MODE (1=edge), 3 POL (1=low),
//                   4 VEC (R), 5 FORCE (W, sets PEND of edge sources)
//   irq_in        : asynchronous requests, bit i is source i
//   enabled       : CPU interrupt enable
//   cpu_exception : registered vector, 0 none, i+1 for source i
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 15,
  parameter int unsigned VEC_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  if_wb.slave                bus,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               enabled,
  output logic [VEC_W-1:0]   cpu_exception
);

  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] mode_q;
  logic [NUM_SRC-1:0] pol_q;
  logic [NUM_SRC-1:0] level;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pend_next;
  logic [NUM_SRC-1:0] wdata;
  logic [NUM_SRC-1:0] clr_bits;
  logic [NUM_SRC-1:0] frc_bits;
  logic [DATA_W-1:0]  rd_data;
  logic [VEC_W-1:0]   vec_next;
  logic               req;
  logic               wr;
  logic               wr_pend;
  logic               wr_mask;
  logic               wr_mode;
  logic               wr_pol;
  logic               wr_force;
  reg_idx_e           idx;
  logic               unused_bus;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .raw   (irq_in[i]),
      .pol   (pol_q[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // Every stb cycle is one access; stall is never raised.
  assign req        = bus.cyc & bus.stb;
  assign wr         = req & bus.we;
  assign idx        = reg_idx_e'(bus.adr[4:2]);
  assign wdata      = bus.dat_w[NUM_SRC-1:0];
  assign bus.stall  = 1'b0;
  assign unused_bus = ^{bus.adr[31:5], bus.adr[1:0], bus.sel, bus.dat_w[DATA_W-1:NUM_SRC]};

  always_comb begin
    wr_pend  = 1'b0;
    wr_mask  = 1'b0;
    wr_mode  = 1'b0;
    wr_pol   = 1'b0;
    wr_force = 1'b0;
    if (wr) begin
      case (idx)
        REG_PEND:  wr_pend  = 1'b1;
        REG_MASK:  wr_mask  = 1'b1;
        REG_MODE:  wr_mode  = 1'b1;
        REG_POL:   wr_pol   = 1'b1;
        REG_FORCE: wr_force = 1'b1;
        default:   ;
      endcase
    end
  end

  assign clr_bits = wr_pend  ? wdata : '0;
  assign frc_bits = wr_force ? wdata : '0;

  // Edge sources: set wins over a simultaneous W1C. Level sources mirror s.
  always_comb begin
    pend_next = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (mode_q[k]) begin
        pend_next[k] = rise[k] | frc_bits[k] | (pend_q[k] & ~clr_bits[k]);
      end else begin
        pend_next[k] = level[k];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      REG_PEND: rd_data[NUM_SRC-1:0] = pend_q;
      REG_MASK: rd_data[NUM_SRC-1:0] = mask_q;
      REG_MODE: rd_data[NUM_SRC-1:0] = mode_q;
      REG_POL:  rd_data[NUM_SRC-1:0] = pol_q;
      REG_VEC:  rd_data[VEC_W-1:0]   = cpu_exception;
      default:  ;
    endcase
  end

  assign vec_next = enabled ? VEC_W'(first_set(DATA_W'(pend_q & mask_q))) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q        <= '0;
      mask_q        <= '0;
      mode_q        <= '0;
      pol_q         <= '0;
      cpu_exception <= '0;
      bus.ack       <= 1'b0;
      bus.dat_r     <= '0;
    end else begin
      pend_q        <= pend_next;
      cpu_exception <= vec_next;
      bus.ack       <= req;
      if (wr_mask) mask_q <= wdata;
      if (wr_mode) mode_q <= wdata;
      if (wr_pol)  pol_q  <= wdata;
      if (req && !bus.we) bus.dat_r <= rd_data;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a cycle-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_irq_controller;

  localparam int unsigned N    = 15;
  localparam int unsigned SYNC = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N-1:0]  irq_in;
  logic          enabled;
  logic [3:0]    cpu_exception;

  if_wb bus ();

  irq_controller #(
    .NUM_SRC    (N),
    .VEC_W      (4),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .bus          (bus),
    .irq_in       (irq_in),
    .enabled      (enabled),
    .cpu_exception(cpu_exception)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_pend, m_mask, m_mode, m_pol;
  logic [N-1:0] m_hist [SYNC];   // m_hist[k] = irq_in seen k+1 edges ago
  int           m_nhist;         // real samples gathered since reset
  logic [N-1:0] m_sprev;
  bit           m_prev_ok;
  logic [3:0]   m_vec;
  bit           m_ack, m_rd;
  logic [31:0]  m_rdata;

  logic [N-1:0] t_s, t_rise, t_clr, t_frc, t_pend;
  bit           t_ok, t_req;
  int           t_idx;

  function automatic logic [3:0] lowest_vec(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      m_pend = '0; m_mask = '0; m_mode = '0; m_pol = '0;
      for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
      m_nhist = 0; m_sprev = '0; m_prev_ok = 0;
      m_vec = '0; m_ack = 0; m_rd = 0;
    end else begin
      t_ok   = (m_nhist >= SYNC);
      t_s    = (t_ok ? m_hist[SYNC-1] : '0) ^ m_pol;
      t_rise = t_s & ~m_sprev & {N{m_prev_ok}};
      t_req  = bus.cyc & bus.stb;
      t_idx  = int'(bus.adr[4:2]);
      m_ack  = t_req;
      m_rd   = t_req & ~bus.we;
      if (m_rd) begin
        case (t_idx)
          0: m_rdata = 32'(m_pend);
          1: m_rdata = 32'(m_mask);
          2: m_rdata = 32'(m_mode);
          3: m_rdata = 32'(m_pol);
          4: m_rdata = 32'(m_vec);
          default: m_rdata = 32'd0;
        endcase
      end
      t_clr = (t_req && bus.we && t_idx == 0) ? bus.dat_w[N-1:0] : '0;
      t_frc = (t_req && bus.we && t_idx == 5) ? bus.dat_w[N-1:0] : '0;
      for (int i = 0; i < N; i++) begin
        if (!m_mode[i])                 t_pend[i] = t_s[i];
        else if (t_rise[i] || t_frc[i]) t_pend[i] = 1'b1;
        else if (t_clr[i])              t_pend[i] = 1'b0;
        else                            t_pend[i] = m_pend[i];
      end
      m_vec = enabled ? lowest_vec(m_pend & m_mask) : 4'd0;
      if (t_req && bus.we && t_idx == 1) m_mask = bus.dat_w[N-1:0];
      if (t_req && bus.we && t_idx == 2) m_mode = bus.dat_w[N-1:0];
      if (t_req && bus.we && t_idx == 3) m_pol  = bus.dat_w[N-1:0];
      m_pend    = t_pend;
      m_sprev   = t_s;
      m_prev_ok = t_ok;
      for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = irq_in;
      if (m_nhist < SYNC) m_nhist++;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (cpu_exception !== m_vec) begin
        n_fail++;
        $display("FAIL model_vec t=%0t: got %0d expected %0d", $time, cpu_exception, m_vec);
      end
      n_tests++;
      if (bus.ack !== m_ack) begin
        n_fail++;
        $display("FAIL model_ack t=%0t: got %0b expected %0b", $time, bus.ack, m_ack);
      end
      if (m_ack && m_rd) begin
        n_tests++;
        if (bus.dat_r !== m_rdata) begin
          n_fail++;
          $display("FAIL model_rdata t=%0t: got 0x%0h expected 0x%0h", $time, bus.dat_r, m_rdata);
        end
      end
    end
  end

  // ---------------- directed helpers (called at a negedge) ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = '0; bus.sel = '0; bus.dat_w = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.cyc = 1; bus.stb = 1; bus.we = 1; bus.adr = a; bus.sel = 4'hF; bus.dat_w = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.adr = a; bus.sel = 4'hF;
    @(negedge clk);
    d = bus.dat_r;
    bus_idle();
  endtask

  localparam logic [31:0] A_PEND = 32'h00, A_MASK = 32'h04, A_MODE = 32'h08;
  localparam logic [31:0] A_POL  = 32'h0C, A_VEC  = 32'h10, A_FORCE = 32'h14;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    rst_i = 1; irq_in = '0; enabled = 1; bus_idle();
    tick(1);
    chk_en = 1;
    tick(2);
    rst_i = 0;

    // reset state
    check("rst_vec", 32'(cpu_exception), 32'd0);
    bus_read(A_PEND, rd); check("rst_pend", rd, 32'h0);
    bus_read(A_MASK, rd); check("rst_mask", rd, 32'h0);
    bus_read(A_MODE, rd); check("rst_mode", rd, 32'h0);
    bus_read(A_POL,  rd); check("rst_pol",  rd, 32'h0);

    // priority among edge sources
    bus_write(A_MASK, 32'h7FFF);
    bus_write(A_MODE, 32'h7FFF);
    irq_in[5] = 1; tick(1); irq_in[5] = 0; tick(2);
    irq_in[2] = 1; tick(1); irq_in[2] = 0; tick(5);
    check("prio_vec3", 32'(cpu_exception), 32'd3);
    bus_read(A_PEND, rd); check("prio_pend", rd, 32'h24);
    bus_write(A_PEND, 32'h4); tick(2);
    check("prio_vec6", 32'(cpu_exception), 32'd6);
    bus_write(A_PEND, 32'h20); tick(2);
    check("prio_vec0", 32'(cpu_exception), 32'd0);

    // latency: PEND after E2, vector after E3
    irq_in[7] = 1;
    tick(3); check("lat_e2", 32'(cpu_exception), 32'd0);
    tick(1); check("lat_e3", 32'(cpu_exception), 32'd8);
    irq_in[7] = 0;
    bus_write(A_PEND, 32'h80); tick(2);
    check("lat_clr", 32'(cpu_exception), 32'd0);

    // level mode
    bus_write(A_MODE, 32'h0);
    bus_write(A_MASK, 32'h1);
    irq_in[0] = 1;
    tick(3); check("lvl_e2", 32'(cpu_exception), 32'd0);
    tick(1); check("lvl_e3", 32'(cpu_exception), 32'd1);
    bus_write(A_PEND, 32'h1); tick(1);
    check("lvl_w1c_vec", 32'(cpu_exception), 32'd1);
    bus_read(A_PEND, rd); check("lvl_w1c_pend", rd, 32'h1);
    irq_in[0] = 0;
    tick(3); check("lvl_fall_e2", 32'(cpu_exception), 32'd1);
    tick(1); check("lvl_fall_e3", 32'(cpu_exception), 32'd0);

    // polarity and enable
    bus_write(A_POL, 32'h2);
    bus_write(A_MASK, 32'h2);
    tick(2);
    check("pol_vec", 32'(cpu_exception), 32'd2);
    bus_read(A_PEND, rd); check("pol_pend", rd, 32'h2);
    enabled = 0; tick(1);
    check("en0_vec", 32'(cpu_exception), 32'd0);
    bus_read(A_PEND, rd); check("en0_pend", rd, 32'h2);
    enabled = 1; tick(1);
    check("en1_vec", 32'(cpu_exception), 32'd2);
    bus_write(A_POL, 32'h0); tick(2);

    // set/clear collision and FORCE
    bus_write(A_MODE, 32'h7FFF);
    bus_write(A_MASK, 32'h7FFF);
    bus_write(A_PEND, 32'h7FFF); tick(2);
    irq_in[3] = 1; tick(2);
    bus_write(A_PEND, 32'h8);          // lands on the same edge as the set
    bus_read(A_PEND, rd); check("coll_pend", rd, 32'h8);
    bus_write(A_FORCE, 32'h10);
    bus_read(A_PEND, rd); check("force_pend", rd, 32'h18);
    check("coll_vec", 32'(cpu_exception), 32'd4);
    irq_in[3] = 0;
    bus_write(A_PEND, 32'h18); tick(2);

    // polarity flip produces an edge
    bus_write(A_POL, 32'h40); tick(3);
    bus_read(A_PEND, rd); check("polflip_pend", rd, 32'h40);
    check("polflip_vec", 32'(cpu_exception), 32'd7);
    bus_write(A_POL, 32'h0);
    bus_write(A_PEND, 32'h40); tick(2);

    // bus behaviour
    bus_write(A_FORCE, 32'h400); tick(2);
    check("force_vec", 32'(cpu_exception), 32'd11);
    bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.adr = A_MASK;
    @(negedge clk);
    check("b2b_ack0", 32'(bus.ack), 32'd1); check("b2b_mask", bus.dat_r, 32'h7FFF);
    bus.adr = 32'h1C;
    @(negedge clk);
    check("b2b_ack1", 32'(bus.ack), 32'd1); check("b2b_unmapped", bus.dat_r, 32'h0);
    bus.adr = A_VEC;
    @(negedge clk);
    check("b2b_ack2", 32'(bus.ack), 32'd1); check("b2b_vec", bus.dat_r, 32'd11);
    bus_idle();
    @(negedge clk);
    check("b2b_ack_end", 32'(bus.ack), 32'd0);
    bus_write(A_MASK, 32'hFFFF_FFFF);
    bus_read(A_MASK, rd); check("mask_width", rd, 32'h7FFF);
    bus_write(32'h18, 32'h0);
    bus_read(A_MASK, rd); check("unmapped_wr", rd, 32'h7FFF);
    bus_write(A_PEND, 32'h400); tick(2);

    // reset in the middle of a write, input held high throughout
    irq_in[0] = 1;
    bus_write(A_POL, 32'h100); tick(4);
    check("pre_rst_vec", 32'(cpu_exception), 32'd1);
    rst_i = 1;
    bus.cyc = 1; bus.stb = 1; bus.we = 1; bus.adr = A_MASK; bus.dat_w = 32'h1;
    @(negedge clk);
    rst_i = 0; bus_idle();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_vec2", 32'(cpu_exception), 32'd0);
    bus_read(A_PEND, rd); check("rst_pend2", rd, 32'h0);
    bus_write(A_MODE, 32'h1);
    bus_read(A_MASK, rd); check("rst_mask2", rd, 32'h0);
    bus_read(A_POL,  rd); check("rst_pol2",  rd, 32'h0);
    bus_write(A_MASK, 32'h1); tick(5);
    check("held_vec", 32'(cpu_exception), 32'd0);
    bus_read(A_PEND, rd); check("held_pend", rd, 32'h0);
    irq_in[0] = 0; tick(3);
    irq_in[0] = 1; tick(4);
    check("rearm_vec", 32'(cpu_exception), 32'd1);
    bus_read(A_PEND, rd); check("rearm_pend", rd, 32'h1);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NUM_SRC, default 15, meaning number of interrupt sources (1..31).
REQ-002 SHALL have parameter VEC_W, default 4, meaning exception vector width; SHALL equal $clog2(NUM_SRC+1).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning input synchronizer depth (1..3).
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1, reset; reset is synchronous and active-high.
REQ-006 SHALL have port bus, if_wb.slave, -, Wishbone register port.
REQ-007 SHALL have port irq_in, input, NUM_SRC, raw asynchronous interrupt requests; bit i is source i.
REQ-008 SHALL have port enabled, input, 1, CPU interrupt enable.
REQ-009 SHALL have port cpu_exception, output, VEC_W, registered vector: 0 means none, i+1 means source i.

Function
REQ-010 SHALL decode registers on bus.adr[4:2] as follows: 0 PEND (read; write-1-to-clear), 1 MASK (RW), 2 MODE (RW; 1 is edge, 0 is level), 3 POL (RW; 1 is active-low), 4 VEC (read-only current cpu_exception), 5 FORCE (write-only; 1 sets PEND for edge sources).
REQ-011 SHALL assert bus.ack exactly one cycle after cyc&stb with stall held 0, and SHALL ack only one access per request cycle.
REQ-012 SHALL perform full 32-bit writes with sel ignored; register bits at or above NUM_SRC SHALL read 0; unmapped reads SHALL return 0; unmapped writes SHALL have no effect.
REQ-013 SHALL pass each irq_in bit through SYNC_STAGES flops, then XOR with POL, giving the normalised level s[i].
REQ-014 SHALL, for an edge source, set PEND[i] on the cycle where s[i]=1 and the previous s[i]=0; PEND[i] SHALL stay set until cleared by a W1C write.
REQ-015 SHALL, for a level source, make PEND[i] equal s[i] each cycle; W1C and FORCE writes SHALL have no effect on level sources.
REQ-016 SHALL give set priority when an edge or FORCE set and a W1C clear hit the same bit in the same cycle.
REQ-017 SHALL NOT clear PEND when MASK is cleared; masked pending bits SHALL remain readable.
REQ-018 SHALL, on each cycle, register cpu_exception as the lowest i with PEND[i]&MASK[i], plus 1, or 0 if none or enabled=0.
REQ-019 SHALL have this latency with SYNC_STAGES=2: irq_in stable high before edge E0 shows in PEND after E2 and in cpu_exception after E3.
REQ-020 SHALL clear no edge history on a MODE or POL change; a resulting 0-to-1 transition of s SHALL count as an edge.
REQ-021 SHALL make a VEC read return the cpu_exception value registered before the access.

Reset
REQ-022 SHALL, on rst_i, clear PEND, MASK, MODE, POL, the synchronizer and edge-history flops, cpu_exception, and bus.ack to 0 on the next clk_i edge.
REQ-023 SHALL abandon an access in flight when reset occurs, with no ack issued and no register written.
REQ-024 SHALL NOT set PEND from an input held high through reset until it returns low and rises again (edge mode).

Structure
REQ-025 SHALL take register index constants (PEND..FORCE) as an enum in package irq_controller_pkg.
REQ-026 SHALL take per-source synchronizer, polarity, and edge detect from one sub-module, irq_sync, instantiated NUM_SRC times via generate.

Verification
REQ-027 SHALL test priority: MASK=0x7FFF, MODE=0x7FFF, pulse irq_in[5] then irq_in[2] -> cpu_exception=3; W1C PEND=0x4 -> 6; W1C 0x20 -> 0.
REQ-028 SHALL test level mode: MODE=0, MASK=0x1, irq_in[0]=1 -> cpu_exception=1 after E3; W1C PEND=1 has no effect; irq_in[0]=0 -> 0 after 3 cycles.
REQ-029 SHALL test polarity and enable: POL=0x2, MODE=0, MASK=0x2, irq_in[1]=0 -> PEND=0x2; enabled=0 -> cpu_exception=0 next cycle, PEND unchanged; enabled=1 -> 2.
REQ-030 SHALL test a collision: edge on source 3 in the same cycle as W1C 0x8 -> PEND[3]=1; FORCE 0x10 with MODE[4]=1 -> PEND[4]=1.
REQ-031 SHALL test bus behaviour: back-to-back reads give ack one cycle after each stb; read adr 7 -> 0; read VEC matches cpu_exception.
REQ-032 SHALL test reset mid-operation: rst_i pulsed during a MASK write with irq_in[0] held high -> all registers 0 and no ack; no PEND until irq_in[0] falls and rises.
